// File: rtl/key_pkg.sv
// Shared constants for the key event FIFO: event word layout and default depth.
package key_pkg;
   localparam int KEY_W      = 5;   // strobe + code
   localparam int KEY_CODE_W = 4;
   localparam int KEY_STROBE = 4;   // bit index of the one-cycle strobe
   localparam int KEY_DEPTH  = 8;
endpackage

// File: rtl/key_fifo_mem.sv
// FIFO storage: synchronous write, asynchronous (show-ahead) read.
module key_fifo_mem #(
   parameter  int DEPTH  = 8,
   parameter  int CODE_W = 4,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              newClock,
   input  logic              wrEn,
   input  logic [AW-1:0]     wrAddr,
   input  logic [CODE_W-1:0] wrData,
   input  logic [AW-1:0]     rdAddr,
   output logic [CODE_W-1:0] rdData
);
   logic [CODE_W-1:0] mem [DEPTH];

   always_ff @(posedge newClock)
      if (wrEn) mem[wrAddr] <= wrData;

   assign rdData = mem[rdAddr];
endmodule

// File: rtl/key_event_fifo.sv
// Key event FIFO: buffers debounced key codes for a consumer, show-ahead head,
// sticky overflow on dropped events. DEPTH must be a power of two, >= 2.
module key_event_fifo
   import key_pkg::*;
#(
   parameter int DEPTH  = KEY_DEPTH,
   parameter int CODE_W = KEY_CODE_W
) (
   input  logic                     newClock,
   input  logic                     resetN,
   input  logic [KEY_W-1:0]         keyPulse,
   input  logic                     popKey,
   input  logic                     clearFlags,
   output logic [CODE_W-1:0]        keyCode,
   output logic                     keyValid,
   output logic [$clog2(DEPTH):0]   keyCount,
   output logic                     keyFull,
   output logic                     overflow
);
   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [AW-1:0]     wrPtr, rdPtr;
   logic [CODE_W-1:0] headCode, wrCode;
   logic              wrReq, doWr, doRd, drop;

   assign keyValid = (keyCount != '0);
   assign keyFull  = (keyCount == FULL_CNT);
   assign wrReq    = keyPulse[KEY_STROBE];
   assign wrCode   = CODE_W'(keyPulse[KEY_CODE_W-1:0]);

   // A read frees a slot on the same edge, so a full FIFO still accepts.
   assign doRd = popKey && keyValid;
   assign doWr = wrReq && (!keyFull || doRd);
   assign drop = wrReq && keyFull && !doRd;

   // Storage is never cleared, so mask the head while empty.
   assign keyCode = keyValid ? headCode : '0;

   key_fifo_mem #(.DEPTH(DEPTH), .CODE_W(CODE_W)) u_mem (
      .newClock (newClock),
      .wrEn     (doWr),
      .wrAddr   (wrPtr),
      .wrData   (wrCode),
      .rdAddr   (rdPtr),
      .rdData   (headCode)
   );

   always_ff @(posedge newClock) begin
      if (!resetN) begin
         wrPtr    <= '0;
         rdPtr    <= '0;
         keyCount <= '0;
         overflow <= 1'b0;
      end else begin
         if (doWr) wrPtr <= wrPtr + 1'b1;
         if (doRd) rdPtr <= rdPtr + 1'b1;
         case ({doWr, doRd})
            2'b10:   keyCount <= keyCount + 1'b1;
            2'b01:   keyCount <= keyCount - 1'b1;
            default: keyCount <= keyCount;
         endcase
         if (drop)            overflow <= 1'b1;
         else if (clearFlags) overflow <= 1'b0;
      end
   end
endmodule

// File: tb/tb_key_event_fifo.sv
// Directed bench for key_event_fifo: expected pop order in a scoreboard queue,
// checked by a monitor on every accepted read; status checked after each step.
module tb_key_event_fifo;
   logic       newClock = 1'b0;
   logic       resetN   = 1'b0;
   logic [4:0] keyPulse = '0;
   logic       popKey   = 1'b0;
   logic       clearFlags = 1'b0;
   logic [3:0] keyCode;
   logic       keyValid;
   logic [3:0] keyCount;
   logic       keyFull;
   logic       overflow;

   key_event_fifo #(.DEPTH(8), .CODE_W(4)) dut (
      .newClock(newClock), .resetN(resetN), .keyPulse(keyPulse), .popKey(popKey),
      .clearFlags(clearFlags), .keyCode(keyCode), .keyValid(keyValid),
      .keyCount(keyCount), .keyFull(keyFull), .overflow(overflow)
   );

   always #5 newClock = ~newClock;

   int         nVec = 0;
   int         nErr = 0;
   logic [3:0] expQ[$];
   int         mdlCnt = 0;
   bit         mdlOvf = 0;

   task automatic chk(input string name, input int got, input int exp);
      nVec++;
      if (got !== exp) begin
         nErr++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Monitor: every accepted read must present the oldest expected code.
   always @(negedge newClock) begin
      if (resetN && popKey && keyValid) begin
         nVec++;
         if (expQ.size() == 0) begin
            nErr++;
            $display("FAIL pop_extra: got code %0d expected no entry", keyCode);
         end else begin
            logic [3:0] e;
            e = expQ.pop_front();
            if (keyCode !== e) begin
               nErr++;
               $display("FAIL pop_order: got code %0d expected %0d", keyCode, e);
            end
         end
      end
   end

   // One clock edge of stimulus; the queue model decides acceptance.
   task automatic step(input bit s, input logic [3:0] c, input bit p, input bit clr);
      bit rd, full;
      keyPulse   = {s, c};
      popKey     = p;
      clearFlags = clr;
      rd   = p && (mdlCnt > 0);
      full = (mdlCnt == 8);
      if (s && (!full || rd)) begin
         expQ.push_back(c);
         if (!rd) mdlCnt++;
      end else if (rd) mdlCnt--;
      if (s && full && !rd) mdlOvf = 1;
      else if (clr)         mdlOvf = 0;
      @(posedge newClock); #1;
      keyPulse = '0; popKey = 0; clearFlags = 0;
   endtask

   task automatic chk_state(input string tag);
      chk({tag, ".count"}, int'(keyCount), mdlCnt);
      chk({tag, ".valid"}, int'(keyValid), int'(mdlCnt > 0));
      chk({tag, ".full"},  int'(keyFull),  int'(mdlCnt == 8));
      chk({tag, ".ovf"},   int'(overflow), int'(mdlOvf));
   endtask

   initial begin
      // Reset with traffic pending: nothing must stick.
      resetN = 0; keyPulse = 5'h13; popKey = 1; clearFlags = 1;
      repeat (2) @(posedge newClock);
      #1; resetN = 1; keyPulse = '0; popKey = 0; clearFlags = 0;
      chk("rst.count", int'(keyCount), 0);
      chk("rst.valid", int'(keyValid), 0);
      chk("rst.full",  int'(keyFull),  0);
      chk("rst.code",  int'(keyCode),  0);
      chk("rst.ovf",   int'(overflow), 0);

      // Basic order: 3, 7, 1
      step(1, 4'd3, 0, 0); step(1, 4'd7, 0, 0); step(1, 4'd1, 0, 0);
      chk("b.count", int'(keyCount), 3);
      chk("b.head",  int'(keyCode),  3);
      step(0, 0, 1, 0); chk("b.head2", int'(keyCode), 7);
      step(0, 0, 1, 0); chk("b.head3", int'(keyCode), 1);
      step(0, 0, 1, 0); chk("b.empty", int'(keyValid), 0);
      step(0, 0, 1, 0); chk("b.popempty", int'(keyCount), 0);

      // Fill with 0..7, ninth write (8) is dropped
      for (int i = 0; i < 8; i++) step(1, 4'(i), 0, 0);
      chk("f.full", int'(keyFull), 1);
      chk("f.ovf0", int'(overflow), 0);
      step(1, 4'd8, 0, 0);
      chk("f.ovf1",  int'(overflow), 1);
      chk("f.count", int'(keyCount), 8);
      chk("f.head",  int'(keyCode),  0);
      step(0, 0, 0, 1);
      chk("f.clr", int'(overflow), 0);
      // Full with write+pop: 9 accepted, 0 popped
      step(1, 4'd9, 1, 0);
      chk("fw.count", int'(keyCount), 8);
      chk("fw.ovf",   int'(overflow), 0);
      chk("fw.head",  int'(keyCode),  1);
      for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
      chk_state("fw.drain");

      // Empty with write+pop: write wins, pop ignored
      step(1, 4'd5, 1, 0);
      chk("e.count", int'(keyCount), 1);
      chk("e.head",  int'(keyCode),  5);
      step(0, 0, 1, 0);
      chk_state("e.drain");

      // 20 interleaved writes wrap both pointers twice
      for (int i = 0; i < 20; i++) begin
         step(1, 4'((i * 7 + 2) % 16), (i >= 2), 0);
         chk_state("w");
      end
      while (mdlCnt > 0) step(0, 0, 1, 0);
      chk_state("w.drain");

      // Drop coincident with clear: set wins
      for (int i = 0; i < 8; i++) step(1, 4'(15 - i), 0, 0);
      step(1, 4'd4, 0, 1);
      chk("sc.ovf", int'(overflow), 1);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
      chk("sc.count", int'(keyCount), 4);
      chk("sc.ovf2",  int'(overflow), 1);

      // Reset mid-operation with a write pending
      resetN = 0; keyPulse = 5'h1c; popKey = 1; clearFlags = 0;
      @(posedge newClock); #1;
      resetN = 1; keyPulse = '0; popKey = 0;
      expQ.delete(); mdlCnt = 0; mdlOvf = 0;
      chk("mr.count", int'(keyCount), 0);
      chk("mr.ovf",   int'(overflow), 0);
      chk("mr.valid", int'(keyValid), 0);
      chk("mr.code",  int'(keyCode),  0);
      step(1, 4'd10, 0, 0);
      chk("mr.resume", int'(keyCode), 10);
      step(0, 0, 1, 0);
      chk_state("end");
      chk("end.q", expQ.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end
endmodule
